// File: rtl/spi_master.sv
// SPI mode-0 master with start/busy/done handshake; LSB first by default.
// Define SPI_MASTER_MSB_FIRST_EN to shift MSB first in both directions.
module spi_master #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              miso_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              cs_n_o,
   output logic              mosi_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  divCnt_q, divCnt_d;
   logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
   logic              holdHalf_q, holdHalf_d;
   logic [DATA_W-1:0] shiftTx_q, shiftTx_d;
   logic [DATA_W-1:0] shiftRx_q, shiftRx_d;
   logic [DATA_W-1:0] rxData_q, rxData_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sclk_q, sclk_d;
   logic              csN_q, csN_d;
   logic              mosi_q, mosi_d;

   logic              phaseEnd;
   logic              firstBit;
   logic              nextBit;
   logic [DATA_W-1:0] shiftTxNext;
   logic [DATA_W-1:0] shiftRxNext;

`ifdef SPI_MASTER_MSB_FIRST_EN
   assign firstBit    = tx_data_i[DATA_W-1];
   assign nextBit     = shiftTx_q[DATA_W-2];
   assign shiftTxNext = {shiftTx_q[DATA_W-2:0], 1'b0};
   assign shiftRxNext = {shiftRx_q[DATA_W-2:0], miso_i};
`else
   assign firstBit    = tx_data_i[0];
   assign nextBit     = shiftTx_q[1];
   assign shiftTxNext = {1'b0, shiftTx_q[DATA_W-1:1]};
   assign shiftRxNext = {miso_i, shiftRx_q[DATA_W-1:1]};
`endif

   assign phaseEnd = (divCnt_q == DIV_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         divCnt_q   <= '0;
         bitCnt_q   <= '0;
         holdHalf_q <= 1'b0;
         shiftTx_q  <= '0;
         shiftRx_q  <= '0;
         rxData_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sclk_q     <= 1'b0;
         csN_q      <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         bitCnt_q   <= bitCnt_d;
         holdHalf_q <= holdHalf_d;
         shiftTx_q  <= shiftTx_d;
         shiftRx_q  <= shiftRx_d;
         rxData_q   <= rxData_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sclk_q     <= sclk_d;
         csN_q      <= csN_d;
         mosi_q     <= mosi_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      divCnt_d   = divCnt_q;
      bitCnt_d   = bitCnt_q;
      holdHalf_d = holdHalf_q;
      shiftTx_d  = shiftTx_q;
      shiftRx_d  = shiftRx_q;
      rxData_d   = rxData_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      sclk_d     = sclk_q;
      csN_d      = csN_q;
      mosi_d     = mosi_q;

      if (state_q != IDLE) begin
         divCnt_d = phaseEnd ? '0 : divCnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = SETUP;
               divCnt_d   = '0;
               bitCnt_d   = '0;
               holdHalf_d = 1'b0;
               shiftTx_d  = tx_data_i;
               shiftRx_d  = '0;
               busy_d     = 1'b1;
               csN_d      = 1'b0;
               mosi_d     = firstBit;
            end
         end
         SETUP, LOW: begin
            if (phaseEnd) begin
               state_d   = HIGH;
               sclk_d    = 1'b1;
               shiftRx_d = shiftRxNext;
            end
         end
         HIGH: begin
            if (phaseEnd) begin
               sclk_d = 1'b0;
               if (bitCnt_q < BIT_LAST) begin
                  state_d   = LOW;
                  bitCnt_d  = bitCnt_q + 1'b1;
                  shiftTx_d = shiftTxNext;
                  mosi_d    = nextBit;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Two half-periods: the final sclk low half, then the cs_n hold half.
            if (phaseEnd) begin
               if (!holdHalf_q) begin
                  holdHalf_d = 1'b1;
               end else begin
                  state_d  = IDLE;
                  csN_d    = 1'b1;
                  mosi_d   = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  rxData_d = shiftRx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rx_data_o = rxData_q;
   assign sclk_o    = sclk_q;
   assign cs_n_o    = csN_q;
   assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default-divider DUT with a bench-side
// slave model, plus a CLK_DIV=1 loopback DUT for back-to-back transfers.
module tb_spi_master;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT A: default parameters, driven by the slave model below
   logic         startA = 1'b0;
   logic [W-1:0] txA    = '0;
   logic         misoA;
   logic         busyA, doneA, sclkA, csA, mosiA;
   logic [W-1:0] rxA;

   // DUT B: CLK_DIV=1, miso looped back from mosi
   logic         startB = 1'b0;
   logic [W-1:0] txB    = '0;
   logic         busyB, doneB, sclkB, csB, mosiB;
   logic [W-1:0] rxB;

   spi_master #(.DATA_W(W), .CLK_DIV(4)) dutA (
      .clk_i(clk), .rst_i(rst), .start_i(startA), .tx_data_i(txA),
      .miso_i(misoA), .busy_o(busyA), .done_o(doneA), .rx_data_o(rxA),
      .sclk_o(sclkA), .cs_n_o(csA), .mosi_o(mosiA));

   spi_master #(.DATA_W(W), .CLK_DIV(1)) dutB (
      .clk_i(clk), .rst_i(rst), .start_i(startB), .tx_data_i(txB),
      .miso_i(mosiB), .busy_o(busyB), .done_o(doneB), .rx_data_o(rxB),
      .sclk_o(sclkB), .cs_n_o(csB), .mosi_o(mosiB));

   int passCount  = 0;
   int checkCount = 0;

   // Position in the word of the i-th bit on the wire
   function automatic int wireIndex(input int i);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return W - 1 - i;
`else
      return i;
`endif
   endfunction

   // Expected wire sequence packed with the first bit in the MSB of the result
   function automatic logic [W-1:0] expectedSeq(input logic [W-1:0] word);
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < W; i++) s[W-1-i] = word[wireIndex(i)];
      return s;
   endfunction

   // Mode-0 slave: presents bits on cs_n fall / sclk fall, captures mosi on sclk rise
   logic         loopA     = 1'b0;
   logic [W-1:0] slaveWord = '0;
   logic [W-1:0] capWord   = '0;
   logic [W-1:0] seqA      = '0;
   logic         slaveBit  = 1'b0;
   int           riseCntA  = 0;
   int           bitIdxA   = 0;
   logic         csPrevA   = 1'b1;
   logic         sclkPrevA = 1'b0;

   assign misoA = loopA ? mosiA : slaveBit;

   always @(csA or sclkA) begin
      if (csPrevA && !csA) begin
         bitIdxA  = 0;
         riseCntA = 0;
         capWord  = '0;
         seqA     = '0;
         slaveBit = slaveWord[wireIndex(0)];
      end else if (!sclkPrevA && sclkA) begin
         if (riseCntA < W) begin
            capWord[wireIndex(riseCntA)] = mosiA;
            seqA[W-1-riseCntA]           = mosiA;
         end
         riseCntA++;
      end else if (sclkPrevA && !sclkA && !csA) begin
         bitIdxA++;
         if (bitIdxA < W) slaveBit = slaveWord[wireIndex(bitIdxA)];
      end
      csPrevA   = csA;
      sclkPrevA = sclkA;
   end

   // Wire-sequence recorder for DUT B
   logic [W-1:0] seqB      = '0;
   int           riseCntB  = 0;
   logic         csPrevB   = 1'b1;
   logic         sclkPrevB = 1'b0;

   always @(csB or sclkB) begin
      if (csPrevB && !csB) begin
         riseCntB = 0;
         seqB     = '0;
      end else if (!sclkPrevB && sclkB) begin
         if (riseCntB < W) seqB[W-1-riseCntB] = mosiB;
         riseCntB++;
      end
      csPrevB   = csB;
      sclkPrevB = sclkB;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done on DUT A, returning cycles since acceptance (-1 on timeout)
   task automatic waitDoneA(output int lat);
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (doneA) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic waitDoneB(output int lat);
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (doneB) begin
            lat = n;
            break;
         end
      end
   endtask

   // Full transfer on DUT A with the per-transfer checks
   task automatic applyStimulus(input string tag, input logic [W-1:0] tx,
                                input logic [W-1:0] sw, input logic loop);
      int           lat;
      logic [W-1:0] expRx;
      expRx     = loop ? tx : sw;
      txA       = tx;
      slaveWord = sw;
      loopA     = loop;
      startA    = 1'b1;
      tick();
      startA = 1'b0;
      txA    = ~tx;
      checkOutput({tag, "_accept"}, {busyA, csA}, 2'b10);
      waitDoneA(lat);
      checkOutput({tag, "_latency"}, lat, 72);
      checkOutput({tag, "_rx"}, rxA, expRx);
      checkOutput({tag, "_slave_cap"}, capWord, tx);
      checkOutput({tag, "_mosi_seq"}, seqA, expectedSeq(tx));
      checkOutput({tag, "_sclk_rises"}, riseCntA, W);
      tick();
      checkOutput({tag, "_done_pulse"}, {doneA, busyA, csA}, 3'b001);
      checkOutput({tag, "_rx_hold"}, rxA, expRx);
   endtask

   typedef struct {
      string        tag;
      logic [W-1:0] tx;
      logic [W-1:0] sw;
      logic         loop;
   } vector_t;

   initial begin
      vector_t      vecs[4];
      int           lat;
      int           doneCnt;
      logic [W-1:0] rtx, rsw;
      logic         rloop;

      vecs[0] = '{"loop_a5",  8'hA5, 8'h00, 1'b1};
      vecs[1] = '{"slave_3c", 8'h81, 8'h3C, 1'b0};
      vecs[2] = '{"slave_ff", 8'h00, 8'hFF, 1'b0};
      vecs[3] = '{"slave_01", 8'hF0, 8'h01, 1'b0};

      // Reset and idle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("idle_a", {csA, sclkA, mosiA, busyA, doneA, rxA}, {5'b10000, 8'h00});
      end
      checkOutput("idle_b", {csB, sclkB, mosiB, busyB, doneB, rxB}, {5'b10000, 8'h00});

      for (int i = 0; i < 4; i++) applyStimulus(vecs[i].tag, vecs[i].tx, vecs[i].sw, vecs[i].loop);

      for (int i = 0; i < 6; i++) begin
         rtx   = W'($urandom);
         rsw   = W'($urandom);
         rloop = 1'($urandom_range(0, 1));
         applyStimulus($sformatf("rand%0d", i), rtx, rsw, rloop);
      end

      // start while busy is ignored
      txA       = 8'h5A;
      slaveWord = 8'hC3;
      loopA     = 1'b0;
      startA    = 1'b1;
      tick();
      startA  = 1'b0;
      doneCnt = 0;
      lat     = -1;
      for (int n = 1; n <= 160; n++) begin
         if (n == 20) begin
            startA = 1'b1;
            txA    = 8'hFF;
         end else begin
            startA = 1'b0;
         end
         tick();
         if (doneA) begin
            doneCnt++;
            if (lat < 0) lat = n;
         end
      end
      startA = 1'b0;
      checkOutput("ignore_done_count", doneCnt, 1);
      checkOutput("ignore_latency", lat, 72);
      checkOutput("ignore_rx", rxA, 8'hC3);
      checkOutput("ignore_slave_cap", capWord, 8'h5A);

      // Reset mid-transfer
      txA       = 8'h33;
      slaveWord = 8'h96;
      startA    = 1'b1;
      tick();
      startA = 1'b0;
      for (int n = 1; n < 30; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid_outputs", {csA, sclkA, mosiA, busyA, doneA, rxA}, {5'b10000, 8'h00});
      doneCnt = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (doneA) doneCnt++;
      end
      checkOutput("rst_mid_no_done", doneCnt, 0);
      applyStimulus("after_rst", 8'h6E, 8'hB7, 1'b0);

      // Back-to-back on the CLK_DIV=1 DUT with start held high
      txB    = 8'h01;
      startB = 1'b1;
      tick();
      txB = 8'hFE;
      checkOutput("b2b_accept1", {busyB, csB}, 2'b10);
      waitDoneB(lat);
      checkOutput("b2b_latency1", lat, 18);
      checkOutput("b2b_rx1", rxB, 8'h01);
      checkOutput("b2b_cs_gap", csB, 1);
      checkOutput("b2b_mosi_seq", seqB, expectedSeq(8'h01));
      tick();
      startB = 1'b0;
      checkOutput("b2b_accept2", {csB, busyB, doneB}, 3'b010);
      waitDoneB(lat);
      checkOutput("b2b_latency2", lat, 18);
      checkOutput("b2b_rx2", rxB, 8'hFE);
      tick();
      checkOutput("b2b_idle", {doneB, busyB, csB}, 3'b001);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation timed out");
      $fatal(1, "[TB] timeout");
   end

endmodule
